// File: rtl/huffman_region_sequencer_pkg.sv
// Shared types and constants for the big_values Huffman region sequencer.
//   state_e        : sequencer FSM states
//   MaxPairs       : largest legal big_values (576 samples / 2)
//   PairW/IdxW/TblW: widths of pair index, sample index and table id
//   is_zero_table(): true for tables that carry no code bits (0, 4, 14)
package huffman_region_sequencer_pkg;

    localparam int unsigned MaxPairs = 288;
    localparam int unsigned PairW    = 9;
    localparam int unsigned IdxW     = 10;
    localparam int unsigned TblW     = 5;

    // Table ids that decode to all-zero pairs without reading the bitstream.
    localparam logic [TblW-1:0] TblZero0  = 5'd0;
    localparam logic [TblW-1:0] TblZero4  = 5'd4;
    localparam logic [TblW-1:0] TblZero14 = 5'd14;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StDecode,
        StZeroFill,
        StDone
    } state_e;

    function automatic logic is_zero_table(input logic [TblW-1:0] tbl);
        return (tbl == TblZero0) || (tbl == TblZero4) || (tbl == TblZero14);
    endfunction

endpackage

// File: rtl/huffman_region_sequencer_region_select.sv
// Combinational region map: clamps the latched granule boundaries and returns the
// Huffman table (and its zero flag) that applies to a given pair index.
//   big_values_i / region1_start_i / region2_start_i : raw latched config
//   table_select0_i..2_i                              : per-region table ids
//   pair_idx_i                                        : pair being looked up
//   big_values_o                                      : big_values clamped to MaxPairs
//   table_o / zero_o                                  : table for pair_idx_i, zero-table flag
module huffman_region_sequencer_region_select
    import huffman_region_sequencer_pkg::*;
(
    input  logic [PairW-1:0] big_values_i,
    input  logic [PairW-1:0] region1_start_i,
    input  logic [PairW-1:0] region2_start_i,
    input  logic [TblW-1:0]  table_select0_i,
    input  logic [TblW-1:0]  table_select1_i,
    input  logic [TblW-1:0]  table_select2_i,
    input  logic [PairW-1:0] pair_idx_i,
    output logic [PairW-1:0] big_values_o,
    output logic [TblW-1:0]  table_o,
    output logic             zero_o
);

    logic [PairW-1:0] region1_clamped;
    logic [PairW-1:0] region2_limited;
    logic [PairW-1:0] region2_clamped;

    always_comb begin
        big_values_o    = (big_values_i > PairW'(MaxPairs)) ? PairW'(MaxPairs) : big_values_i;
        region1_clamped = (region1_start_i > big_values_o) ? big_values_o : region1_start_i;
        region2_limited = (region2_start_i > big_values_o) ? big_values_o : region2_start_i;
        // region2 may never start before region1, so an inverted config collapses region1.
        region2_clamped = (region2_limited < region1_clamped) ? region1_clamped
                                                              : region2_limited;

        if (pair_idx_i < region1_clamped) begin
            table_o = table_select0_i;
        end else if (pair_idx_i < region2_clamped) begin
            table_o = table_select1_i;
        end else begin
            table_o = table_select2_i;
        end
        zero_o = is_zero_table(table_o);
    end

endmodule

// File: rtl/huffman_region_sequencer.sv
// Sequences Huffman decoding of one granule's big_values region. Splits the pairs into
// region0/1/2, steers the serial bitstream into the shared HT_xx decoder bank with the
// per-region table id, and emits each decoded (x, y) pair with its sample index.
//   clk, rst                 : clock, synchronous active-high reset
//   start_i + config inputs  : start pulse latches big_values/region starts/tables in idle
//   bit_valid_in_i, bit_in_i : serial bitstream; bit_ready_o marks a consumed bit
//   ht_sel_o, ht_rst_o       : decoder bank table select and clear
//   ht_bit_valid_o, ht_bit_o : bit handed to the selected decoder
//   ht_valid_i, ht_x_i/y_i   : decoded pair from the selected decoder
//   out_valid_o, out_index_o : registered pair strobe, sample index of out_x_o
//   out_x_o, out_y_o         : decoded values (out_y_o sits at out_index_o + 1)
//   busy_o, done_o           : granule in progress, one-cycle completion pulse
module huffman_region_sequencer
    import huffman_region_sequencer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [PairW-1:0]        big_values_i,
    input  logic [PairW-1:0]        region1_start_i,
    input  logic [PairW-1:0]        region2_start_i,
    input  logic [TblW-1:0]         table_select0_i,
    input  logic [TblW-1:0]         table_select1_i,
    input  logic [TblW-1:0]         table_select2_i,
    input  logic                    bit_valid_in_i,
    input  logic                    bit_in_i,
    output logic                    bit_ready_o,
    output logic [TblW-1:0]         ht_sel_o,
    output logic                    ht_rst_o,
    output logic                    ht_bit_valid_o,
    output logic                    ht_bit_o,
    input  logic                    ht_valid_i,
    input  logic signed [15:0]      ht_x_i,
    input  logic signed [15:0]      ht_y_i,
    output logic                    out_valid_o,
    output logic [IdxW-1:0]         out_index_o,
    output logic signed [15:0]      out_x_o,
    output logic signed [15:0]      out_y_o,
    output logic                    busy_o,
    output logic                    done_o
);

    state_e             state_q;
    state_e             next_pair_state;
    logic [PairW-1:0]   pair_idx_q, pair_idx_d;
    logic [TblW-1:0]    tbl_q;
    logic [PairW-1:0]   cfg_big_values_q;
    logic [PairW-1:0]   cfg_region1_q;
    logic [PairW-1:0]   cfg_region2_q;
    logic [TblW-1:0]    cfg_table0_q, cfg_table1_q, cfg_table2_q;
    logic               out_valid_q;
    logic [IdxW-1:0]    out_index_q;
    logic signed [15:0] out_x_q, out_y_q;
    logic               advance;

    logic [PairW-1:0]   sel_big_values;
    logic [TblW-1:0]    sel_table;
    logic               sel_zero;

    // Looked up with the next pair index so the table for the pair that follows an
    // increment is already in tbl_q when that pair starts: no extra boundary bubble.
    huffman_region_sequencer_region_select u_region_select (
        .big_values_i    (cfg_big_values_q),
        .region1_start_i (cfg_region1_q),
        .region2_start_i (cfg_region2_q),
        .table_select0_i (cfg_table0_q),
        .table_select1_i (cfg_table1_q),
        .table_select2_i (cfg_table2_q),
        .pair_idx_i      (pair_idx_d),
        .big_values_o    (sel_big_values),
        .table_o         (sel_table),
        .zero_o          (sel_zero)
    );

    always_comb begin
        unique case (state_q)
            StDecode:   advance = ht_valid_i;
            StZeroFill: advance = 1'b1;
            default:    advance = 1'b0;
        endcase

        if ((state_q == StIdle) || (state_q == StSetup)) begin
            pair_idx_d = '0;
        end else if (advance) begin
            pair_idx_d = pair_idx_q + PairW'(1);
        end else begin
            pair_idx_d = pair_idx_q;
        end

        if (pair_idx_d == sel_big_values) begin
            next_pair_state = StDone;
        end else if (sel_zero) begin
            next_pair_state = StZeroFill;
        end else begin
            next_pair_state = StDecode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            pair_idx_q       <= '0;
            tbl_q            <= '0;
            cfg_big_values_q <= '0;
            cfg_region1_q    <= '0;
            cfg_region2_q    <= '0;
            cfg_table0_q     <= '0;
            cfg_table1_q     <= '0;
            cfg_table2_q     <= '0;
            out_valid_q      <= 1'b0;
            out_index_q      <= '0;
            out_x_q          <= '0;
            out_y_q          <= '0;
        end else begin
            pair_idx_q  <= pair_idx_d;
            out_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        cfg_big_values_q <= big_values_i;
                        cfg_region1_q    <= region1_start_i;
                        cfg_region2_q    <= region2_start_i;
                        cfg_table0_q     <= table_select0_i;
                        cfg_table1_q     <= table_select1_i;
                        cfg_table2_q     <= table_select2_i;
                        state_q          <= StSetup;
                    end
                end
                StSetup: begin
                    tbl_q   <= sel_table;
                    state_q <= next_pair_state;
                end
                StDecode: begin
                    if (ht_valid_i) begin
                        out_valid_q <= 1'b1;
                        out_index_q <= {pair_idx_q, 1'b0};
                        out_x_q     <= ht_x_i;
                        out_y_q     <= ht_y_i;
                        tbl_q       <= sel_table;
                        state_q     <= next_pair_state;
                    end
                end
                StZeroFill: begin
                    out_valid_q <= 1'b1;
                    out_index_q <= {pair_idx_q, 1'b0};
                    out_x_q     <= '0;
                    out_y_q     <= '0;
                    tbl_q       <= sel_table;
                    state_q     <= next_pair_state;
                end
                StDone: begin
                    // The last pair's strobe lands in the first DONE cycle; done follows it.
                    if (!out_valid_q) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The ht_valid cycle is a bubble: no bit is taken while the decoder hands over a pair.
    assign bit_ready_o    = (state_q == StDecode) && !ht_valid_i;
    assign ht_bit_valid_o = bit_valid_in_i && bit_ready_o;
    assign ht_bit_o       = (state_q == StDecode) && bit_in_i;
    assign ht_sel_o       = (state_q == StDecode) ? tbl_q : '0;
    assign ht_rst_o       = rst || (state_q == StSetup);
    assign out_valid_o    = out_valid_q;
    assign out_index_o    = out_index_q;
    assign out_x_o        = out_x_q;
    assign out_y_o        = out_y_q;
    assign busy_o         = (state_q != StIdle);
    assign done_o         = (state_q == StDone) && !out_valid_q;

endmodule

// File: doc/huffman_region_sequencer.md
# huffman_region_sequencer

Sequences Huffman decoding of one granule's big_values region in the MP3 parser. It splits the pairs into region0/1/2 and selects the per-region table for the shared bank of HT_xx pair decoders. It gates the serial bitstream into the active decoder and emits each decoded (x, y) pair with its sample index. It sits between the side-info parser and the sample RAM, ahead of count1 decoding.

## Interface
- MAX_PAIRS, 288: maximum big_values (576 samples / 2)
- IDX_W, 10: width of sample index
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse; latches config, begins granule
- big_values  in  9  pair count for region
- region1_start  in  9  first pair index of region1
- region2_start  in  9  first pair index of region2
- table_select0/1/2  in  5 each  Huffman table per region
- bit_valid_in  in  1  serial bit present
- bit_in  in  1  serial bit
- bit_ready  out  1  bit consumed this cycle
- ht_sel  out  5  active table id to decoder bank
- ht_rst  out  1  clear all decoders
- ht_bit_valid  out  1  axiiv to selected decoder
- ht_bit  out  1  axiid to selected decoder
- ht_valid  in  1  selected decoder axiov
- ht_x, ht_y  in  16 signed each  decoded pair
- out_valid  out  1  pair output strobe
- out_index  out  IDX_W  sample index of out_x (out_y is index+1)
- out_x, out_y  out  16 signed each  decoded values
- busy  out  1  granule in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SETUP, DECODE, ZERO_FILL, DONE.
- IDLE: start latches config. Clamps:
  - big_values to MAX_PAIRS.
  - region1_start to big_values.
  - region2_start to max(region1_start, min(region2_start, big_values)).
  - Then go to SETUP. start is ignored in every other state.
- SETUP: ht_rst=1 for exactly one cycle, pair_idx=0. Next state:
  - DONE if big_values=0.
  - ZERO_FILL if the current table is 0, 4 or 14.
  - DECODE otherwise.
- Current table:
  - table_select0 when pair_idx<region1_start.
  - table_select1 when pair_idx<region2_start.
  - table_select2 otherwise.
- DECODE:
  - bit_ready = !ht_valid.
  - ht_bit_valid = bit_valid_in && bit_ready.
  - ht_bit = bit_in.
  - ht_sel = current table.
  - When ht_valid=1: register the pair to the outputs, increment pair_idx, and consume no bit that cycle. This bubble lets the decoder clear and lets the table change at a region boundary.
- ZERO_FILL: emit (0,0) once per cycle with bit_ready=0, until pair_idx leaves the region or reaches big_values.
- After each pair increment, re-evaluate the table. Go to DONE if pair_idx=big_values, otherwise to DECODE or ZERO_FILL.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- out_index = 2*pair_idx of the emitted pair.

## Timing
- Reset values: state=IDLE. bit_ready, ht_bit_valid, ht_bit, out_valid, done and busy are 0. ht_rst=1 during rst. ht_sel=0, out_index=0, out_x=0, out_y=0.
- Start sequence:
  - start sampled at edge N.
  - SETUP in cycle N+1 (ht_rst high).
  - First bit may be accepted in cycle N+2.
- out_valid is registered: it goes high the cycle after ht_valid, for one cycle.
- ZERO_FILL: one out_valid per cycle.
- done asserts the cycle after the final out_valid.
- A pair of k code bits occupies k+1 cycles of bit_ready time at full input rate (k accept cycles plus one bubble).
- bit_valid_in low stalls DECODE indefinitely; no timeout.
- rst mid-granule:
  - Return to IDLE next cycle.
  - Pending pair discarded, no out_valid, no done.
  - ht_rst asserted during rst.
- A region boundary at an index where both adjacent regions are non-zero tables must switch ht_sel with no extra bubble beyond the normal one.

## Structure
- mp3_pkg holds:
  - State enum.
  - MAX_PAIRS.
  - Table-id constants, including the zero tables {0,4,14}.
  - A function is_zero_table(tbl).
- One sub-module, ht_region_select: clamps the boundaries and maps pair_idx to the current table and a zero flag. It is combinational, instantiated once.
- The HT_xx decoder bank and mux stay outside this block.

## Test plan
- big_values=3, regions 1/2 at 3, table_select0=29, bits encode pairs (0,0),(1,0),(-15-5=−20 via linbits),… → 3 out_valid at indices 0,2,4, values matching the model, then done.
- big_values=4, region1_start=2, tables 0 and 1 → indices 0,2 emit (0,0) on consecutive cycles with no bits consumed; indices 4,6 are decoded from table 1, with ht_sel=1 only after pair 2.
- big_values=0 → done pulse exactly 2 cycles after start, no out_valid, bit_ready never high.
- bit_valid_in toggled 50% random during a 10-pair table-29 run → same outputs as the full-rate run, and bit_ready=0 in every ht_valid cycle.
- rst asserted while pair 5 of 8 is in progress → IDLE next cycle, no further out_valid, no done. A subsequent start decodes correctly from index 0.
- big_values=400, region starts 500/600 → clamped to 288 pairs. The final out_index is 574, then done. start pulses during busy are ignored.
